// File: rtl/fp_result_stage.sv
// Output stage of the single-precision adder: special-case encoding of the
// composed result, 2-entry valid/ready FIFO, sticky overflow and delivery count.
module fp_result_stage #(
    parameter int N     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             float_number_sgn,
    input  logic [7:0]       float_number_exp,
    input  logic [22:0]      float_number_man,
    input  logic             overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     result,
    output logic             res_overflow,
    output logic             res_zero,
    output logic             sticky_ovf,
    input  logic             clr_sticky,
    output logic [CNT_W-1:0] res_count
);

    typedef struct packed {
        logic [N-1:0] word;
        logic         ovf;
        logic         zero;
    } entry_t;

    entry_t          enc;
    entry_t          head;
    entry_t          tail;
    logic [1:0]      occ;
    logic            push;
    logic            pop;
    logic            sticky_q;
    logic [CNT_W-1:0] count_q;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        enc = '0;
        if (overflow || float_number_exp == 8'hFF) begin
            enc.word = {float_number_sgn, 8'hFF, 23'h0};
            enc.ovf  = 1'b1;
        end else if (float_number_exp == 8'h00) begin
            // Denormals flush to signed zero whatever the mantissa holds.
            enc.word = {float_number_sgn, 31'h0};
            enc.zero = 1'b1;
        end else begin
            enc.word = {float_number_sgn, float_number_exp, float_number_man};
        end
    end

    assign in_ready  = (occ != 2'd2);
    assign out_valid = (occ != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Head/tail shift organisation: the head register holds its last value
    // after the final pop, so result stays put while the FIFO is empty.
    always_ff @(posedge clk) begin
        // NOTE: both storage entries are reset so result reads 0 out of reset;
        // with only two entries this costs nothing worth avoiding.
        if (rst) begin
            occ      <= 2'd0;
            head     <= '0;
            tail     <= '0;
            sticky_q <= 1'b0;
            count_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) head <= enc;
                    else             tail <= enc;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    if (occ == 2'd2) head <= tail;
                    occ <= occ - 2'd1;
                end
                2'b11: head <= enc;  // only reachable at occupancy 1
                default: ;
            endcase

            if (push && enc.ovf) sticky_q <= 1'b1;
            else if (clr_sticky) sticky_q <= 1'b0;

            if (pop) count_q <= count_q + 1'b1;
        end
    end

    assign result       = head.word;
    assign res_overflow = head.ovf;
    assign res_zero     = head.zero;
    assign sticky_ovf   = sticky_q;
    assign res_count    = count_q;

endmodule

// File: tb/tb_fp_result_stage.sv
// Scoreboard bench for fp_result_stage: directed test-plan sequences followed
// by randomized traffic, checked against a queue-based reference model.
module tb_fp_result_stage;

    localparam int N  = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          sgn;
    logic [7:0]    expo;
    logic [22:0]   man;
    logic          ovf_in;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  result;
    logic          res_overflow;
    logic          res_zero;
    logic          sticky_ovf;
    logic          clr_sticky;
    logic [CW-1:0] res_count;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] word;
        bit          ovf;
        bit          zero;
    } exp_t;

    exp_t          sb[$];
    exp_t          last_head;
    bit            m_sticky;
    logic [CW-1:0] m_count;
    bit            armed = 0;

    fp_result_stage #(.N(N), .CNT_W(CW)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .float_number_sgn (sgn),
        .float_number_exp (expo),
        .float_number_man (man),
        .overflow         (ovf_in),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .result           (result),
        .res_overflow     (res_overflow),
        .res_zero         (res_zero),
        .sticky_ovf       (sticky_ovf),
        .clr_sticky       (clr_sticky),
        .res_count        (res_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference encoding from the IEEE special-case rules, as plain arithmetic.
    function automatic exp_t model_enc(bit s, int e, int m, bit o);
        exp_t r;
        longint sign_bit = s ? 64'h8000_0000 : 64'h0;
        r.ovf  = 0;
        r.zero = 0;
        if (o || e == 255) begin
            r.word = 32'(sign_bit + 255 * (1 << 23));
            r.ovf  = 1;
        end else if (e == 0) begin
            r.word = 32'(sign_bit);
            r.zero = 1;
        end else begin
            r.word = 32'(sign_bit + longint'(e) * (1 << 23) + m);
        end
        return r;
    endfunction

    // Monitor: compares outputs against the model mid-cycle, then advances the
    // model with the handshakes that the coming rising edge will perform.
    always @(negedge clk) begin
        bit do_push;
        bit do_pop;
        exp_t e;
        if (armed && !rst) begin
            check("in_ready", in_ready, (sb.size() < 2));
            check("out_valid", out_valid, (sb.size() > 0));
            check("sticky_ovf", sticky_ovf, m_sticky);
            check("res_count", res_count, m_count);
            if (sb.size() > 0) begin
                check("head_word", result, sb[0].word);
                check("head_flags", {res_overflow, res_zero}, {sb[0].ovf, sb[0].zero});
            end else begin
                check("idle_word", result, last_head.word);
                check("idle_flags", {res_overflow, res_zero}, {last_head.ovf, last_head.zero});
            end
        end
        if (rst) begin
            sb.delete();
            last_head = '{32'h0, 0, 0};
            m_sticky  = 0;
            m_count   = '0;
            armed     = 1;
        end else if (armed) begin
            do_push = in_valid && (sb.size() < 2);
            do_pop  = out_ready && (sb.size() > 0);
            e = model_enc(sgn, int'(expo), int'(man), ovf_in);
            if (do_pop) begin
                last_head = sb.pop_front();
                m_count++;
            end
            if (do_push) sb.push_back(e);
            if (do_push && e.ovf) m_sticky = 1;
            else if (clr_sticky)  m_sticky = 0;
        end
    end

    task automatic step(input bit v, input bit s, input logic [7:0] e, input logic [22:0] m,
                        input bit o, input bit ordy, input bit clr);
        in_valid   = v;
        sgn        = s;
        expo       = e;
        man        = m;
        ovf_in     = o;
        out_ready  = ordy;
        clr_sticky = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit ordy);
        step(0, 0, 8'h00, 23'h0, 0, ordy, 0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 0; sgn = 0; expo = '0; man = '0; ovf_in = 0; out_ready = 0; clr_sticky = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_result", result, 32'h0);
        check("rst_count", res_count, 0);
        check("rst_sticky", sticky_ovf, 0);

        // Normal number, delivered the cycle after push.
        step(1, 0, 8'h80, 23'h400000, 0, 1, 0);
        check("a_valid", out_valid, 1);
        check("a_word", result, 32'h40400000);
        check("a_flags", {res_overflow, res_zero}, 2'b00);
        idle(1);
        check("a_count", res_count, 1);
        check("a_empty", out_valid, 0);

        // Overflow to infinity and sticky behaviour.
        step(1, 1, 8'h12, 23'h1234, 1, 1, 0);
        check("ovf_word", result, 32'hFF800000);
        check("ovf_flag", res_overflow, 1);
        check("ovf_sticky", sticky_ovf, 1);
        step(1, 0, 8'h40, 23'h0, 1, 1, 1);
        check("sticky_set_wins", sticky_ovf, 1);
        step(0, 0, 8'h00, 23'h0, 0, 1, 1);
        check("sticky_clear", sticky_ovf, 0);
        idle(1);

        // Denormal flushes to signed zero.
        step(1, 1, 8'h00, 23'h1, 0, 1, 0);
        check("zero_word", result, 32'h80000000);
        check("zero_flag", res_zero, 1);
        idle(1);

        // Back-pressure: fill both entries, third offer refused, in-order drain.
        step(1, 0, 8'h7F, 23'h0, 0, 0, 0);
        step(1, 0, 8'h80, 23'h0, 0, 0, 0);
        check("full_in_ready", in_ready, 0);
        check("full_head_a", result, 32'h3F800000);
        step(1, 0, 8'h81, 23'h7, 0, 0, 0);
        check("full_hold_a", result, 32'h3F800000);
        check("full_still", in_ready, 0);
        idle(1);
        check("drain_in_ready", in_ready, 1);
        check("drain_head_b", result, 32'h40000000);
        idle(1);
        check("drain_empty", out_valid, 0);

        // Occupancy 1 with simultaneous push and pop.
        step(1, 0, 8'h85, 23'h1, 0, 0, 0);
        step(1, 1, 8'h90, 23'h55, 0, 1, 0);
        check("swap_valid", out_valid, 1);
        check("swap_head_c", result, 32'hC8000055);
        idle(1);

        // Counter wrap on the 4-bit variant: 16 pops from a fresh reset.
        rst = 1'b1; idle(0); rst = 1'b0;
        for (int i = 0; i < 16; i++) step(1, 0, 8'(8'h10 + i), 23'(i), 0, 1, 0);
        idle(1);
        check("wrap_count", res_count, 0);

        // Reset with both entries held and sticky set.
        step(1, 0, 8'hFF, 23'h0, 0, 0, 0);
        step(1, 0, 8'h33, 23'h0, 0, 0, 0);
        check("pre_rst_full", in_ready, 0);
        rst = 1'b1; idle(0); rst = 1'b0;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_count", res_count, 0);
        check("mid_rst_sticky", sticky_ovf, 0);
        check("mid_rst_result", result, 32'h0);

        // Randomized traffic with biased special exponents and rare resets.
        for (int i = 0; i < 3000; i++) begin
            int sel = $urandom_range(0, 9);
            logic [7:0] e = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom);
            rst = ($urandom_range(0, 299) == 0);
            step($urandom_range(0, 2) != 0, 1'($urandom), e, 23'($urandom),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 9) == 0);
        end
        rst = 1'b0;
        idle(1);
        idle(1);
        idle(1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fp_result_stage.md
Name: fp_result_stage

Overview:
- Output stage of the single-precision adder pipeline; sits directly downstream of the result-composition phase.
- Consumes the composed sign, exponent, mantissa and overflow bit, and applies special-case encoding (overflow to infinity, exponent zero to signed zero).
- Buffers packed results in a 2-entry FIFO with valid/ready handshake toward the consumer.
- Keeps a sticky overflow flag and a count of results delivered.

Parameters:
- N, 32, packed result width; only 32 is supported.
- CNT_W, 16, width of the delivered-result counter.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  upstream presents a composed result.
- in_ready  output  1  stage can accept a result this cycle.
- float_number_sgn  input  1  result sign.
- float_number_exp  input  8  result exponent.
- float_number_man  input  23  result mantissa.
- overflow  input  1  exponent carry-out from upstream.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  consumer accepts the head entry.
- result  output  N  packed IEEE-754 word at the FIFO head.
- res_overflow  output  1  head entry was encoded as infinity.
- res_zero  output  1  head entry was flushed to zero.
- sticky_ovf  output  1  set by any accepted overflowing result.
- clr_sticky  input  1  clears sticky_ovf.
- res_count  output  CNT_W  number of results popped.

Behaviour:
- Reset (rst=1 at clk edge):
  - FIFO empty: out_valid=0, in_ready=1.
  - result=0, res_overflow=0, res_zero=0.
  - sticky_ovf=0, res_count=0.
  - Reset mid-transfer discards both entries.
- Handshakes:
  - Push when in_valid && in_ready.
  - Pop when out_valid && out_ready.
  - in_ready = (occupancy < 2). It is registered-state derived only; there is no combinational path from out_ready.
- Encoding, applied at push, in priority order:
  - overflow=1 or exp==8'hFF: word={sgn,8'hFF,23'h0}; ovf flag=1, zero flag=0.
  - else exp==8'h00: word={sgn,31'h0}; zero flag=1. Denormals are flushed regardless of mantissa.
  - else: word={sgn,exp,man}; both flags 0.
- FIFO:
  - 2 entries, each holding {word, ovf flag, zero flag}.
  - Occupancy is 0, 1 or 2.
  - result, res_overflow and res_zero always show the head entry. They hold their last value when empty (out_valid=0); the consumer ignores them then.
- Latency: a push at edge k makes the entry visible at the head after edge k when the FIFO was empty. It is visible one cycle after the preceding entry pops otherwise.
- Simultaneous push and pop:
  - Occupancy 1: occupancy stays 1; the new entry becomes head at the next edge.
  - Occupancy 2: push is impossible (in_ready=0). The pop reduces occupancy to 1, and in_ready rises in the following cycle.
  - Occupancy 0: pop is impossible (out_valid=0).
- Data stability: while out_valid=1 and out_ready=0, result and flags hold stable. In-order delivery is guaranteed.
- sticky_ovf:
  - Set on a push whose encoded ovf flag=1.
  - Cleared when clr_sticky=1.
  - Set and clear in the same cycle: set wins.
- res_count: increments by 1 on each pop and wraps from 2^CNT_W-1 to 0.
- Inputs are sampled only on push; values while in_valid=0 are don't-care.

Test Plan:
- Reset, then push sgn=0, exp=8'h80, man=23'h400000 with out_ready=1 -> next cycle out_valid=1, result=32'h40400000, flags 0; after pop res_count=1.
- Push overflow=1, sgn=1, exp=8'h12 -> result=32'hFF800000, res_overflow=1, sticky_ovf=1. clr_sticky plus a new overflowing push in the same cycle -> sticky_ovf stays 1. clr_sticky alone -> 0.
- Push exp=8'h00, man=23'h1, sgn=1 -> result=32'h80000000, res_zero=1.
- Hold out_ready=0 and push A=32'h3F800000 then B=32'h40000000 -> in_ready=0 after the second push, result stable at A. A third in_valid is not accepted. Release out_ready -> A then B delivered in order; in_ready=1 one cycle after the first pop.
- Occupancy 1 with simultaneous push C and pop -> occupancy stays 1; C appears at the head next cycle.
- Preload res_count near wrap (CNT_W=4 variant): 16 pops -> res_count returns to 0. Assert rst with 2 entries held -> out_valid=0, in_ready=1, counters 0 next cycle.
